// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter feeding a shared UART TX FIFO, with an in-flight byte counter.
// Optional header byte per frame when UART_TX_ARB_HDR_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    input  logic                   fifo_full,
    input  logic                   transmission_complete,
    output logic                   trans_start,
    output logic [7:0]             data_in,
    output logic [CNT_W-1:0]       in_flight,
    output logic                   line_idle
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (CNT_W < $clog2(FIFO_DEPTH + 2)) begin : g_cnt_w_check
        $error("CNT_W cannot hold FIFO_DEPTH+1");
    end

`ifdef UART_TX_ARB_HDR_EN
    typedef enum logic [1:0] {IDLE, XFER, HDR} state_t;
`else
    typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

    state_t               state, state_n;
    logic [IDX_W-1:0]     gidx, gidx_n;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_n;
    logic [NUM_REQ-1:0]   grant_n;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    int unsigned          cand;

    // First requester after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!pick_found && req[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gidx   <= '0;
            grant  <= '0;
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else begin
            state  <= state_n;
            gidx   <= gidx_n;
            grant  <= grant_n;
            rr_ptr <= rr_ptr_n;
        end
    end

    // Next state plus same-cycle FIFO write handshake
    always_comb begin
        state_n     = state;
        gidx_n      = gidx;
        grant_n     = grant;
        rr_ptr_n    = rr_ptr;
        trans_start = 1'b0;
        data_in     = 8'h00;
        req_ack     = '0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gidx_n  = pick_idx;
                    grant_n = NUM_REQ'(1) << pick_idx;
`ifdef UART_TX_ARB_HDR_EN
                    state_n = HDR;
`else
                    state_n = XFER;
`endif
                end
            end
`ifdef UART_TX_ARB_HDR_EN
            HDR: begin
                data_in = 8'hA0 | 8'(gidx);
                if (!fifo_full) begin
                    trans_start = 1'b1;
                    state_n     = XFER;
                end
            end
`endif
            XFER: begin
                trans_start   = req[gidx] & ~fifo_full;
                data_in       = req_data[{gidx, 3'b000} +: 8];
                req_ack[gidx] = trans_start;
                if (trans_start && req_last[gidx]) begin
                    rr_ptr_n = gidx;
                    grant_n  = '0;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
        if (rst) begin
            trans_start = 1'b0;
            req_ack     = '0;
            busy        = 1'b0;
            data_in     = 8'h00;
        end
    end

    // Saturating bytes-in-flight counter; simultaneous push and complete cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else if (trans_start && !transmission_complete && in_flight != CNT_MAX) begin
            in_flight <= in_flight + CNT_W'(1);
        end else if (!trans_start && transmission_complete && in_flight != '0) begin
            in_flight <= in_flight - CNT_W'(1);
        end
    end

    assign line_idle = (in_flight == '0) && (state == IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx_top instance between NUM_REQ byte-stream requesters.
- Each requester presents a frame: a byte sequence terminated by a last flag.
- The arbiter grants whole frames in round-robin order and pushes the granted requester's bytes into the TX FIFO (trans_start/data_in), respecting fifo_full.
- It counts bytes in flight, so software and upper logic can tell when the serial line is fully drained.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FIFO_DEPTH, 16, depth of the TX FIFO behind uart_tx_top; sets the in-flight counter range.
- CNT_W, 5, width of the in-flight counter; must hold FIFO_DEPTH+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester "byte valid".
- req_data  in  NUM_REQ*8  packed bytes; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  current byte is the final byte of the frame.
- req_ack  out  NUM_REQ  one-hot pulse: requester's byte was written to the FIFO this cycle.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy  out  1  a frame is in progress (state is not IDLE).
- fifo_full  in  1  from uart_tx_top.
- transmission_complete  in  1  from uart_tx_top; one-cycle pulse per byte fully shifted out.
- trans_start  out  1  FIFO write strobe to uart_tx_top.
- data_in  out  8  byte to uart_tx_top.
- in_flight  out  CNT_W  bytes pushed but not yet completed.
- line_idle  out  1  high when in_flight==0 and state is IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (rst).
- Reset values: state=IDLE, grant=0, rr_ptr=NUM_REQ-1, in_flight=0, line_idle=1.
  - Combinational outputs under reset: trans_start=0, req_ack=0, busy=0, data_in=0.
- FSM state IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - Register the choice into grant and go to XFER next cycle.
  - Consequence: one dead cycle between frames.
- FSM state XFER:
  - trans_start = req[g] & ~fifo_full, computed combinationally in the same cycle, so FIFO occupancy is never overrun.
  - data_in = req_data[g]; req_ack[g] = trans_start.
  - If trans_start & req_last[g]: set rr_ptr=g, grant=0, go to IDLE.
- Grant is held for the whole frame.
  - A requester dropping req mid-frame stalls the arbiter in XFER; there is no timeout.
  - Other requests are ignored until the frame's last byte is accepted.
- fifo_full high: no write and no ack; the byte is held by the requester (valid/ack handshake; req_data must stay stable while req & ~req_ack).
- in_flight:
  - +1 on trans_start; -1 on transmission_complete.
  - Both in the same cycle: unchanged.
  - Saturates at 0 (a stray complete is ignored) and at 2^CNT_W-1.
- line_idle is registered-consistent: it is computed from the current in_flight and state.
- A single-byte frame (req_last on the first byte) occupies the grant for one XFER cycle minimum.
- rst asserted mid-frame: returns to reset values next edge.
  - Bytes already in uart_tx_top are not recalled; uart_tx_top shares rst.

Optional Feature:
- Macro: UART_TX_ARB_HDR_EN.
- When defined:
  - IDLE goes to a HDR state instead of XFER.
  - HDR writes header byte 8'hA0 | g (g = granted index) when ~fifo_full, with no req_ack, then moves to XFER.
  - The header counts toward in_flight.
- When undefined: no HDR state; output bytes are exactly the requesters' bytes.

Test Plan:
- rst for 2 cycles, then idle -> trans_start=0, grant=0, in_flight=0, line_idle=1.
- req[0] frame 8'h11, 8'h22 (last), fifo_full=0 -> grant=4'b0001 one cycle after req; data_in 11, 22 on consecutive cycles; req_ack[0] twice; return to IDLE; in_flight=2.
- req=4'b1111 held, each frame 1 byte -> grant order 0,1,2,3,0 (round-robin wrap); exactly one gap cycle between frames.
- fifo_full forced high for 5 cycles mid-frame of requester 2 -> no trans_start and no req_ack for those cycles; held byte written the cycle fifo_full drops.
- Push 3 bytes, then pulse transmission_complete on the same cycle as the 3rd push, then 2 more pulses -> in_flight goes 1,2,2,1,0; line_idle=1 at end.
- With UART_TX_ARB_HDR_EN, req[3] single byte 8'h5C -> data_in 8'hA3 then 8'h5C; req_ack[3] only on the second write; in_flight=2.
